// File: rtl/rnn_sched_pkg.sv
// rnn_sched_pkg
//   Shared types and constants for the RNN sequence scheduler:
//   FSM state encoding, rnn slave register addresses, input element
//   selector codes and the helper that packs an INPUT register write.
package rnn_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_I0,
        WR_I1,
        START,
        WAIT,
        DENSE,
        POLL,
        RESULT,
        OUT
    } state_e;

    localparam logic [31:0] ADDR_START        = 32'd0;
    localparam logic [31:0] ADDR_INPUT        = 32'd1;
    localparam logic [31:0] ADDR_DENSE_RESULT = 32'd7;

    localparam logic [7:0] SEL_ELEM0 = 8'd0;
    localparam logic [7:0] SEL_ELEM1 = 8'd1;

    // INPUT register layout: [23:16] element select, [15:0] element value.
    function automatic logic [31:0] input_word(logic [7:0] sel, logic [15:0] elem);
        return {8'h00, sel, elem};
    endfunction

endpackage

// File: rtl/rnn_seq_sched_timer.sv
// sched_timer
//   Loadable down-counter shared by the step-wait and DONE-poll phases.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     load_i        load load_val_i (takes priority over dec_i)
//     load_val_i    value to load
//     dec_i         decrement by one (holds at zero)
//     last_o        count is on its final tick: a decrement this cycle
//                   brings it to zero (also high when already zero)
module sched_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (dec_i && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    // Flag from the registered count only, so the FSM can act on it in the
    // same cycle it requests the decrement without a combinational loop.
    assign last_o = (value_q <= W'(1));

endmodule

// File: rtl/rnn_seq_sched.sv
// rnn_seq_sched
//   Bus master that walks the rnn slave through a whole sequence: for each
//   input character it writes both elements and a START, waits the step
//   latency, and after the last character fires the dense layer, polls
//   DONE and returns the 16-bit result (or an error on poll timeout).
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     in_valid/in_ready/in_data/in_last   character stream in
//     out_valid/out_ready/out_data/out_err result out
//     cfg_step_wait                 wait cycles after START (floored)
//     m_read/m_write/m_addr/m_wdata/m_rdata  rnn slave bus (registered out)
//     busy, char_count              status
module rnn_seq_sched
    import rnn_sched_pkg::*;
#(
    parameter int STEP_WAIT_MIN = 8,
    parameter int POLL_TIMEOUT  = 256,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_err,
    input  logic [7:0]       cfg_step_wait,
    output logic             m_read,
    output logic             m_write,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] char_count
);

    // Wide enough for both the poll budget and any 8-bit step wait.
    localparam int TMR_W = $clog2((POLL_TIMEOUT > 255) ? (POLL_TIMEOUT + 1) : 256);
    localparam logic [7:0] WAIT_MIN8 = 8'(STEP_WAIT_MIN);

    state_e             state_q, state_d;
    logic [31:0]        data_q, data_d;
    logic               last_q, last_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_err_q, out_err_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               m_read_q, m_read_d;
    logic               m_write_q, m_write_d;
    logic [31:0]        m_addr_q, m_addr_d;
    logic [31:0]        m_wdata_q, m_wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               tmr_load, tmr_dec, tmr_last;
    logic [TMR_W-1:0]   tmr_load_val;
    logic [TMR_W-1:0]   step_wait;
    logic               rdata_unused;

    assign step_wait    = (cfg_step_wait < WAIT_MIN8) ? TMR_W'(WAIT_MIN8) : TMR_W'(cfg_step_wait);
    assign rdata_unused = ^m_rdata[31:16];

    sched_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .last_o     (tmr_last)
    );

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        last_d       = last_q;
        out_err_d    = out_err_q;
        out_data_d   = out_data_q;
        cnt_d        = cnt_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = WR_I0;
                end
            end
            WR_I0: state_d = WR_I1;
            WR_I1: state_d = START;
            START: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = step_wait;
                state_d      = WAIT;
            end
            WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_last) state_d = last_q ? DENSE : IDLE;
            end
            DENSE: begin
                tmr_load     = 1'b1;
                tmr_load_val = TMR_W'(POLL_TIMEOUT);
                state_d      = POLL;
            end
            POLL: begin
                if (m_rdata[0]) begin
                    state_d = RESULT;
                end else begin
                    tmr_dec = 1'b1;
                    if (tmr_last) begin
                        out_err_d  = 1'b1;
                        out_data_d = 16'h0000;
                        state_d    = OUT;
                    end
                end
            end
            RESULT: begin
                // This read also moves the rnn back to its LOAD phase.
                out_data_d = m_rdata[15:0];
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_err_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are decoded from the next state so that they are
        // registered yet line up with the state that owns them.
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
        m_addr_d  = '0;
        m_wdata_d = '0;
        case (state_d)
            WR_I0: begin
                m_write_d = 1'b1;
                m_addr_d  = ADDR_INPUT;
                m_wdata_d = input_word(SEL_ELEM0, data_d[15:0]);
            end
            WR_I1: begin
                m_write_d = 1'b1;
                m_addr_d  = ADDR_INPUT;
                m_wdata_d = input_word(SEL_ELEM1, data_d[31:16]);
            end
            START: begin
                m_write_d = 1'b1;
                m_addr_d  = ADDR_START;
            end
            DENSE: begin
                m_write_d = 1'b1;
                m_addr_d  = ADDR_DENSE_RESULT;
            end
            POLL: begin
                m_read_d = 1'b1;
                m_addr_d = ADDR_START;
            end
            RESULT: begin
                m_read_d = 1'b1;
                m_addr_d = ADDR_DENSE_RESULT;
            end
            default: ;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_data_q  <= out_data_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_err    = out_err_q;
    assign out_data   = out_data_q;
    assign m_read     = m_read_q;
    assign m_write    = m_write_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign char_count = cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rnn_seq_sched.sv
module tb_rnn_seq_sched;

    localparam int STEP_WAIT_MIN = 8;
    localparam int POLL_TIMEOUT  = 256;
    localparam int CNT_W         = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_last;
    logic [31:0]      in_data;
    logic             out_valid, out_ready, out_err;
    logic [15:0]      out_data;
    logic [7:0]       cfg_step_wait;
    logic             m_read, m_write;
    logic [31:0]      m_addr, m_wdata, m_rdata;
    logic             busy;
    logic [CNT_W-1:0] char_count;

    rnn_seq_sched #(
        .STEP_WAIT_MIN (STEP_WAIT_MIN),
        .POLL_TIMEOUT  (POLL_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_err       (out_err),
        .cfg_step_wait (cfg_step_wait),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .busy          (busy),
        .char_count    (char_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t bus_log[$];   // every strobe cycle seen on the bus
    txn_t expq[$];      // transactions the sequence should produce

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          proto_err = 0;
    bit          mon_en = 1'b0;
    int          done_on = 0;      // DONE seen on this poll number; 0 = never
    logic [15:0] res_val = '0;
    int          poll_cnt = 0;
    logic        done_now;

    always @(posedge clk) cyc <= cyc + 1;

    // rnn slave model: DONE on the done_on-th poll after a DENSE write,
    // result register returns res_val with junk in the upper half.
    always @(posedge clk) begin
        if (m_write && m_addr == 32'd7)     poll_cnt <= 0;
        else if (m_read && m_addr == 32'd0) poll_cnt <= poll_cnt + 1;
    end

    always_comb begin
        done_now = (done_on != 0) && (poll_cnt + 1 >= done_on);
        m_rdata  = 32'h0;
        if (m_read && m_addr == 32'd0)      m_rdata = {30'h0, 1'b1, done_now};
        else if (m_read && m_addr == 32'd7) m_rdata = {16'hA5A5, res_val};
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_read || m_write) bus_log.push_back('{cyc, m_read, m_write, m_addr, m_wdata});
            assert (!(m_read && m_write)) else begin
                proto_err++;
                $error("FAIL bus_both_strobes cycle %0d", cyc);
            end
            assert (m_read || m_write || (m_addr == 32'd0 && m_wdata == 32'd0)) else begin
                proto_err++;
                $error("FAIL bus_idle_nonzero cycle %0d addr %0h wdata %0h", cyc, m_addr, m_wdata);
            end
            assert (!((in_ready || out_valid) && (m_read || m_write))) else begin
                proto_err++;
                $error("FAIL bus_strobe_in_idle_or_out cycle %0d", cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input bit rd, input logic [31:0] addr, input logic [31:0] wdata);
        expq.push_back('{0, rd, !rd, addr, wdata});
    endtask

    // Called right after a negedge; returns right after the negedge that
    // follows the accepting clock edge.
    task automatic send_char(input logic [31:0] d, input bit last);
        int k;
        k        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_err"},   out_err, 0);
        check({tag, "_out_data"},  out_data, 0);
        check({tag, "_m_read"},    m_read, 0);
        check({tag, "_m_write"},   m_write, 0);
        check({tag, "_m_addr"},    m_addr, 0);
        check({tag, "_m_wdata"},   m_wdata, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_char_count"}, char_count, 0);
    endtask

    task automatic run_seq(input int n, input int cfg, input int don, input int hold, input bit fixed);
        logic [15:0] e0, e1, held;
        int base, w, k, s, npoll, b;
        base    = bus_log.size();
        expq.delete();
        done_on = don;
        res_val = 16'($urandom);
        cfg_step_wait = 8'(cfg);
        w = (cfg > STEP_WAIT_MIN) ? cfg : STEP_WAIT_MIN;

        for (int i = 0; i < n; i++) begin
            e0 = fixed ? 16'(2 + 2 * i) : 16'($urandom);
            e1 = fixed ? 16'(3 + 2 * i) : 16'($urandom);
            exp_push(0, 32'd1, {16'h0000, e0});
            exp_push(0, 32'd1, {16'h0001, e1});
            exp_push(0, 32'd0, 32'd0);
            send_char({e1, e0}, (i == n - 1));
        end
        exp_push(0, 32'd7, 32'd0);
        npoll = (don == 0) ? POLL_TIMEOUT : don;
        for (int p = 0; p < npoll; p++) exp_push(1, 32'd0, 32'd0);
        if (don != 0) exp_push(1, 32'd7, 32'd0);

        k = 0;
        while (!out_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_wait", out_valid, 1);
        check("out_data",   out_data, (don != 0) ? res_val : 16'h0000);
        check("out_err",    out_err, (don == 0));
        check("char_count", char_count, (n > 255) ? 255 : n);
        check("busy_out",   busy, 1);

        held = out_data;
        for (int h = 0; h < hold; h++) begin
            s = bus_log.size();
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data",  out_data, held);
            check("bp_in_ready",  in_ready, 0);
            check("bp_no_bus",    bus_log.size(), s);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_in_ready",   in_ready, 1);
        check("post_out_valid",  out_valid, 0);
        check("post_out_err",    out_err, 0);
        check("post_busy",       busy, 0);
        check("post_char_count", char_count, 0);

        check("txn_count", bus_log.size() - base, expq.size());
        for (int i = 0; i < expq.size() && base + i < bus_log.size(); i++) begin
            check("txn_kind", {bus_log[base+i].rd, bus_log[base+i].wr}, {expq[i].rd, expq[i].wr});
            check("txn_addr_data", {bus_log[base+i].addr, bus_log[base+i].wdata},
                                   {expq[i].addr, expq[i].wdata});
        end
        if (bus_log.size() - base == expq.size()) begin
            for (int i = 0; i < n; i++) begin
                b = base + 3 * i;
                check("gap_i0_i1",    bus_log[b+1].cyc - bus_log[b].cyc, 1);
                check("gap_i0_start", bus_log[b+2].cyc - bus_log[b].cyc, 2);
                if (i > 0) check("gap_start_start", bus_log[b+2].cyc - bus_log[b-1].cyc, w + 4);
            end
            b = base + 3 * n;
            check("gap_start_dense", bus_log[b].cyc - bus_log[b-1].cyc, w + 1);
            check("gap_dense_poll",  bus_log[b+1].cyc - bus_log[b].cyc, 1);
            check("gap_poll_span",   bus_log[b+npoll].cyc - bus_log[b+1].cyc, npoll - 1);
            if (don != 0) check("gap_poll_result", bus_log[b+npoll+1].cyc - bus_log[b+npoll].cyc, 1);
        end
    endtask

    initial begin
        int base, k;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        out_ready     = 1'b0;
        cfg_step_wait = 8'd0;

        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_in_ready", in_ready, 1);

        // single char {2,3}, DONE on the 3rd poll
        run_seq(1, 20, 3, 0, 1'b1);
        // three chars at the step-wait floor
        run_seq(3, 0, 2, 0, 1'b0);
        // result held under backpressure
        run_seq(1, 5, 1, 10, 1'b0);
        // DONE never arrives
        run_seq(1, 0, 0, 0, 1'b0);

        // reset while waiting on the second character's step
        done_on       = 2;
        cfg_step_wait = 8'd10;
        base          = bus_log.size();
        send_char($urandom, 1'b0);
        send_char($urandom, 1'b0);
        k = 0;
        while (bus_log.size() - base < 6 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_second_start", bus_log.size() - base, 6);
        @(negedge clk);
        check("rst_pre_busy",       busy, 1);
        check("rst_pre_char_count", char_count, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy",     busy, 0);

        // randomized sequences
        for (int t = 0; t < 6; t++) begin
            run_seq($urandom_range(1, 4), $urandom_range(0, 30), $urandom_range(1, 6),
                    $urandom_range(0, 3), 1'b0);
        end

        @(negedge clk);
        check("bus_protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
